rice_write_controller: RTL and testbench

RICE_WRITE_CONTROLLER -- requirements
Module: rice_write_controller

---
 rtl/rice_write_controller_pkg.sv | 45 ++++
 rtl/rice_merge_fifo.sv | 67 ++++++
 rtl/rice_write_controller.sv | 216 +++++++++++++++++++++
 tb/tb_rice_write_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_write_controller_pkg.sv
`default_nettype none
// ============================================================================
// rice_write_controller_pkg : shared FSM states, constants and Rice code math
// Revision: 1.0
// ============================================================================
package rice_write_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRESET = 3'd1,
        S_HEADER = 3'd2,
        S_RUN    = 3'd3,
        S_PAD    = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam int unsigned C_HEADER_W  = 4;
    localparam logic [15:0] C_MAX_UPPER = 16'd31;

    typedef struct packed {
        logic [15:0] upper;
        logic [15:0] lower;
        logic [15:0] total;
        logic        err;
    } code_t;

    // Over-long unary prefixes are clamped; err flags the clamp.
    function automatic code_t rice_code(input logic [15:0] r, input logic [3:0] k);
        logic [15:0] u;
        logic [15:0] mask;
        logic [15:0] raw;
        code_t       c;
        u       = {r[14:0], 1'b0} ^ {16{r[15]}};
        mask    = (16'd1 << k) - 16'd1;
        raw     = u >> k;
        c.err   = (raw > C_MAX_UPPER);
        c.upper = c.err ? C_MAX_UPPER : raw;
        c.lower = (16'd1 << k) | (u & mask);
        c.total = c.upper + {12'd0, k} + 16'd1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rice_merge_fifo.sv
`default_nettype none
// ============================================================================
// rice_merge_fifo : two-write / one-read FIFO with empty-bypass read port
// Revision: 1.0
// ============================================================================
module rice_merge_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push1_i,
    input  logic [WIDTH-1:0]           data1_i,
    input  logic                       push2_i,
    input  logic [WIDTH-1:0]           data2_i,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;

    logic             w_empty;
    logic             w_any;
    logic             w_both;
    logic             w_pop;
    logic [1:0]       w_npush;
    logic [WIDTH-1:0] w_first;

    assign w_empty    = (count_q == '0);
    assign w_any      = push1_i | push2_i;
    assign w_both     = push1_i & push2_i;
    assign w_first    = push1_i ? data1_i : data2_i;
    assign w_npush    = {1'b0, push1_i} + {1'b0, push2_i};
    // The reader never stalls, so anything readable is popped this cycle.
    assign w_pop      = !w_empty || w_any;
    assign rd_valid_o = w_pop;
    assign rd_data_o  = w_empty ? w_first : mem_q[rptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (w_any) begin
            mem_q[wptr_q] <= w_first;
        end
        if (w_both) begin
            mem_q[wptr_q + AW'(1)] <= data2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(w_npush);
            rptr_q  <= rptr_q + AW'(w_pop);
            count_q <= count_q + (AW+1)'(w_npush) - (AW+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rice_write_controller.sv
`default_nettype none
// ============================================================================
// rice_write_controller : drives a Rice bit writer and merges its RAM strobes
// Revision: 1.0
// ============================================================================
module rice_write_controller #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [15:0] iSampleCount,
    input  logic [3:0]  iRiceParam,
    input  logic [15:0] iResidual,
    input  logic        iValid,
    output logic        oReady,
    output logic        oWriterEnable,
    output logic        oWriterReset,
    output logic [15:0] oTotal,
    output logic [15:0] oUpper,
    output logic [15:0] oLower,
    output logic [3:0]  oRiceParam,
    input  logic        iRamEnable1,
    input  logic [15:0] iRamAddress1,
    input  logic [15:0] iRamData1,
    input  logic        iRamEnable2,
    input  logic [15:0] iRamAddress2,
    input  logic [15:0] iRamData2,
    output logic        oRamWE,
    output logic [15:0] oRamAddress,
    output logic [15:0] oRamData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oCodeErr
);
    import rice_write_controller_pkg::*;

    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  READY_MAX = CW'(FIFO_DEPTH - 4);

    state_e      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [15:0] remain_q, remain_d;
    logic [3:0]  mirror_q, mirror_d;
    logic        wen_q, wen_d;
    logic        wrst_q, wrst_d;
    logic [15:0] total_q, total_d;
    logic [15:0] upper_q, upper_d;
    logic [15:0] lower_q, lower_d;
    logic [3:0]  rparam_q, rparam_d;
    logic        err_q, err_d;
    logic        wen_dly_q;
    logic [1:0]  gap_q;
    logic        ram_we_q;
    logic [15:0] ram_addr_q;
    logic [15:0] ram_data_q;

    logic          w_ready;
    logic          w_accept;
    code_t         w_code;
    logic [CW-1:0] w_fifo_count;
    logic          w_pop_valid;
    logic [31:0]   w_pop_data;

    assign w_code   = rice_code(iResidual, k_q);
    assign w_ready  = (state_q == S_RUN) && (w_fifo_count <= READY_MAX) && (remain_q != 16'd0);
    assign w_accept = iValid && w_ready;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        remain_d = remain_q;
        mirror_d = mirror_q;
        wen_d    = 1'b0;
        wrst_d   = 1'b0;
        total_d  = total_q;
        upper_d  = upper_q;
        lower_d  = lower_q;
        rparam_d = rparam_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d  = S_WRESET;
                    k_d      = iRiceParam;
                    remain_d = iSampleCount;
                    err_d    = 1'b0;
                    wrst_d   = 1'b1;
                end
            end
            S_WRESET: begin
                state_d  = S_HEADER;
                wen_d    = 1'b1;
                rparam_d = k_q;
                upper_d  = 16'd0;
                lower_d  = 16'd0;
                total_d  = 16'(C_HEADER_W);
                mirror_d = 4'(C_HEADER_W);
            end
            S_HEADER, S_RUN: begin
                if (remain_q == 16'd0) begin
                    // Close the current 16-bit word with zeros and a stop bit.
                    if (mirror_q != 4'd0) begin
                        state_d  = S_PAD;
                        wen_d    = 1'b1;
                        rparam_d = 4'd0;
                        upper_d  = 16'd15 - {12'd0, mirror_q};
                        lower_d  = 16'd1;
                        total_d  = 16'd16 - {12'd0, mirror_q};
                        mirror_d = 4'd0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_RUN;
                    if (w_accept) begin
                        wen_d    = 1'b1;
                        rparam_d = k_q;
                        upper_d  = w_code.upper;
                        lower_d  = w_code.lower;
                        total_d  = w_code.total;
                        mirror_d = mirror_q + w_code.total[3:0];
                        remain_d = remain_q - 16'd1;
                        if (w_code.err) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_PAD:   state_d = S_DRAIN;
            S_DRAIN: begin
                if ((w_fifo_count == '0) && (gap_q == 2'd2)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            k_q        <= 4'd0;
            remain_q   <= 16'd0;
            mirror_q   <= 4'd0;
            wen_q      <= 1'b0;
            wrst_q     <= 1'b0;
            total_q    <= 16'd0;
            upper_q    <= 16'd0;
            lower_q    <= 16'd0;
            rparam_q   <= 4'd0;
            err_q      <= 1'b0;
            wen_dly_q  <= 1'b0;
            gap_q      <= 2'd2;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 16'd0;
            ram_data_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            remain_q   <= remain_d;
            mirror_q   <= mirror_d;
            wen_q      <= wen_d;
            wrst_q     <= wrst_d;
            total_q    <= total_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            rparam_q   <= rparam_d;
            err_q      <= err_d;
            wen_dly_q  <= wen_q;
            if (wen_q) begin
                gap_q <= 2'd0;
            end else if (gap_q != 2'd2) begin
                gap_q <= gap_q + 2'd1;
            end
            ram_we_q <= w_pop_valid;
            if (w_pop_valid) begin
                ram_addr_q <= w_pop_data[31:16];
                ram_data_q <= w_pop_data[15:0];
            end
        end
    end

    // The writer holds its strobes, so they are only fresh right after an enable.
    rice_merge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i      (iClock),
        .rst_i      (iReset),
        .push1_i    (wen_dly_q & iRamEnable1),
        .data1_i    ({iRamAddress1, iRamData1}),
        .push2_i    (wen_dly_q & iRamEnable2),
        .data2_i    ({iRamAddress2, iRamData2}),
        .rd_valid_o (w_pop_valid),
        .rd_data_o  (w_pop_data),
        .count_o    (w_fifo_count)
    );

    assign oReady        = w_ready;
    assign oWriterEnable = wen_q;
    assign oWriterReset  = wrst_q;
    assign oTotal        = total_q;
    assign oUpper        = upper_q;
    assign oLower        = lower_q;
    assign oRiceParam    = rparam_q;
    assign oRamWE        = ram_we_q;
    assign oRamAddress   = ram_addr_q;
    assign oRamData      = ram_data_q;
    assign oBusy         = (state_q != S_IDLE);
    assign oDone         = (state_q == S_DONE);
    assign oCodeErr      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rice_write_controller.sv
`default_nettype none
// ============================================================================
// tb_rice_write_controller : directed bench with a bit-writer model
// Revision: 1.0
// ============================================================================
module tb_rice_write_controller;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sample_count = 16'd0;
    logic [3:0]  rice_param = 4'd0;
    logic [15:0] residual = 16'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic        wen, wrst;
    logic [15:0] total, upper, lower;
    logic [3:0]  rparam;
    logic        ram_en1, ram_en2;
    logic [15:0] ram_addr1, ram_data1, ram_addr2, ram_data2;
    logic        ram_we;
    logic [15:0] ram_addr, ram_data;
    logic        busy, done, code_err;

    always #5 clk = ~clk;

    rice_write_controller #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .iClock(clk), .iReset(rst), .iStart(start), .iSampleCount(sample_count),
        .iRiceParam(rice_param), .iResidual(residual), .iValid(valid), .oReady(ready),
        .oWriterEnable(wen), .oWriterReset(wrst), .oTotal(total), .oUpper(upper),
        .oLower(lower), .oRiceParam(rparam),
        .iRamEnable1(ram_en1), .iRamAddress1(ram_addr1), .iRamData1(ram_data1),
        .iRamEnable2(ram_en2), .iRamAddress2(ram_addr2), .iRamData2(ram_data2),
        .oRamWE(ram_we), .oRamAddress(ram_addr), .oRamData(ram_data),
        .oBusy(busy), .oDone(done), .oCodeErr(code_err)
    );

    typedef struct packed {
        logic        hdr;
        logic [3:0]  rp;
        logic [15:0] up;
        logic [15:0] lo;
        logic [15:0] tot;
    } exp_t;

    exp_t        exp_q[$];
    int          res_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          words_seen = 0;
    int          done_seen = 0;
    int          wrst_seen = 0;
    int          drops = 0;
    int          exp_words = 0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_addr = 16'd0;

    task automatic check(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
        n_checks++;
        if (obsv !== expv) begin
            $display("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int zigzag(input int r);
        return (r >= 0) ? 2 * r : -2 * r - 1;
    endfunction

    // Bit-writer model: returns one strobe per completed 16-bit word, held until the next enable.
    initial begin
        int wbits;
        int n;
        logic [15:0] waddr;
        wbits = 0; waddr = 16'd0;
        ram_en1 = 1'b0; ram_en2 = 1'b0;
        ram_addr1 = 16'd0; ram_data1 = 16'd0; ram_addr2 = 16'd0; ram_data2 = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wbits = 0; waddr = 16'd0; ram_en1 = 1'b0; ram_en2 = 1'b0;
            end else if (wrst) begin
                wbits = 0; waddr = 16'd0;
            end else if (wen) begin
                n = ((wbits % 16) + int'(total)) / 16;
                wbits += int'(total);
                @(posedge clk);
                #1;
                ram_en1 = (n >= 1);
                ram_addr1 = waddr; ram_data1 = waddr ^ 16'h5A5A;
                if (n >= 1) waddr++;
                ram_en2 = (n >= 2);
                ram_addr2 = waddr; ram_data2 = waddr ^ 16'h5A5A;
                if (n >= 2) waddr++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wrst) begin
                    wrst_seen++;
                    exp_addr = 16'd0;
                end
                if (wen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_enable", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.hdr) begin
                            check("hdr_after_wrst", 64'(wrst_seen), 64'd1);
                            check("hdr_param", 64'(rparam), 64'(e.rp));
                        end else begin
                            check("code_param", 64'(rparam), 64'(e.rp));
                            check("code_upper", 64'(upper), 64'(e.up));
                            check("code_lower", 64'(lower), 64'(e.lo));
                            check("code_total", 64'(total), 64'(e.tot));
                        end
                    end
                end
                if (ram_we) begin
                    check("ram_addr", 64'(ram_addr), 64'(exp_addr));
                    check("ram_data", 64'(ram_data), 64'(exp_addr ^ 16'h5A5A));
                    exp_addr++;
                    words_seen++;
                end
                if (done) done_seen++;
            end
        end
    end

    task automatic build_model(input logic [3:0] k);
        int mir, bits, u, up, lo, tot;
        exp_q.delete();
        exp_err = 1'b0;
        mir = 4; bits = 4;
        exp_q.push_back('{1'b1, k, 16'd0, 16'd0, 16'd0});
        foreach (res_q[i]) begin
            u  = zigzag(res_q[i]);
            up = u >> k;
            if (up > 31) begin
                up = 31;
                exp_err = 1'b1;
            end
            lo  = (1 << k) | (u & ((1 << k) - 1));
            tot = up + int'(k) + 1;
            mir = (mir + tot) % 16;
            bits += tot;
            exp_q.push_back('{1'b0, k, 16'(up), 16'(lo), 16'(tot)});
        end
        if (mir != 0) begin
            exp_q.push_back('{1'b0, 4'd0, 16'(15 - mir), 16'd1, 16'(16 - mir)});
            bits += 16 - mir;
        end
        exp_words = bits / 16;
    endtask

    task automatic start_frame(input logic [3:0] k);
        wrst_seen = 0; words_seen = 0; done_seen = 0; drops = 0;
        @(posedge clk); #1;
        start = 1'b1; sample_count = 16'(res_q.size()); rice_param = k;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic send(input int upto, input int glitch);
        for (int i = 0; i < upto; i++) begin
            bit got;
            bit rdy;
            got = 1'b0;
            valid = 1'b1;
            residual = 16'(res_q[i]);
            for (int t = 0; t < 200 && !got; t++) begin
                start = (i == glitch);
                @(negedge clk);
                rdy = ready;
                if (!rdy && i > 0) drops++;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (rdy) got = 1'b1;
            end
            if (!got) check("ready_timeout", 64'd0, 64'd1);
        end
        valid = 1'b0;
    endtask

    task automatic finish_frame(input string nm);
        for (int t = 0; t < 2000 && done_seen == 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_done_once"}, 64'(done_seen), 64'd1);
        check({nm, "_words"}, 64'(words_seen), 64'(exp_words));
        check({nm, "_codes_left"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_code_err"}, 64'(code_err), 64'(exp_err));
        check({nm, "_wreset_cycles"}, 64'(wrst_seen), 64'd1);
        check({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2;
        check("rst_fields", {total, upper, lower, rparam}, 64'd0);
        check("rst_flags", {ram_addr, ram_data, wen, wrst, ram_we, busy, done, code_err, ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready", 64'(ready), 64'd0);

        // k=2, small residuals, one word, no stall
        res_q = '{0, -1, 1};
        build_model(4'd2);
        start_frame(4'd2);
        send(res_q.size(), -1);
        check("small_no_stall", 64'(drops), 64'd0);
        finish_frame("k2");

        // k=0 overflow of the unary prefix
        res_q = '{20};
        build_model(4'd0);
        start_frame(4'd0);
        send(res_q.size(), -1);
        finish_frame("clamp");

        // empty frame, k=5: header plus pad only; clears the sticky error
        res_q.delete();
        build_model(4'd5);
        start_frame(4'd5);
        finish_frame("empty");

        // 64 large residuals, two words per code, stray iStart mid-frame
        res_q.delete();
        for (int i = 0; i < 64; i++) res_q.push_back(((i % 2) != 0) ? -(1000 + 37 * i) : (1000 + 37 * i));
        build_model(4'd0);
        start_frame(4'd0);
        send(res_q.size(), 10);
        check("ready_throttled", 64'(drops > 0), 64'd1);
        finish_frame("stream");

        // asynchronous reset in the middle of RUN
        res_q.delete();
        for (int i = 0; i < 20; i++) res_q.push_back(500 + i);
        build_model(4'd0);
        start_frame(4'd0);
        send(5, -1);
        @(negedge clk);
        check("err_before_rst", 64'(code_err), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_fields", {total, upper, lower, rparam}, 64'd0);
        check("midrst_flags", {ram_addr, ram_data, wen, wrst, ram_we, busy, done, code_err, ready}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        res_q = '{7, -8, 100};
        build_model(4'd3);
        start_frame(4'd3);
        send(res_q.size(), -1);
        finish_frame("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
